i2c_arbiter: RTL
================

# i2c_arbiter

Shares the single `i2c` controller between two configuration requesters: port A for the HDMI transmitter config queue and port B for the audio codec config queue. Each requester sees the same start/busy interface it would see on a dedicated controller. The arbiter captures each command, grants the bus round-robin, issues one `i2c` transaction at a time and reports completion. A stuck controller is detected by a timeout. The block sits between the config queues and the `i2c` instance, and runs on `clk_60kHz`.

## Interface
- `TIMEOUT_CYCLES`, 4095: max cycles to wait for `i2c_busy` to rise after `i2c_start`, or to fall once high.
- `clk`  in  1  shared 60 kHz I2C-domain clock.
- `rst`  in  1  reset, synchronous, active-low.
- `a_start`, `b_start`  in  1  one-cycle command strobe per requester.
- `a_address`, `b_address`  in  7  I2C slave address; sampled only on the strobe cycle.
- `a_data_0`, `a_data_1`, `b_data_0`, `b_data_1`  in  8 each  register and value bytes; sampled only on the strobe cycle.
- `a_busy`, `b_busy`  out  1  high from the cycle after an accepted strobe until that requester's done/error.
- `a_done`, `b_done`  out  1  one-cycle pulse when the transaction completes normally.
- `a_error`, `b_error`  out  1  one-cycle pulse on timeout; `busy` falls in the same cycle.
- `i2c_start`  out  1  one-cycle strobe to the controller.
- `i2c_address`  out  7  registered command to the controller; holds its last value.
- `i2c_data_0`, `i2c_data_1`  out  8 each  registered command to the controller; hold their last values.
- `i2c_busy`  in  1  controller busy.
- `grant`  out  2  one-hot owner of the bus. 00 means idle.

## Operation
- Each port has a slot: a pending flag plus a captured 23-bit command.
  - A strobe while the slot is empty captures the command and sets pending. `x_busy` equals pending.
  - A strobe while pending is ignored, with no state change.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
  - **IDLE.** If any port is pending, select a port, load its command into the `i2c_*` output registers, set `grant`, and go to ISSUE.
  - **ISSUE.** Assert `i2c_start` for exactly this cycle, clear the timer, and go to WAIT_ACK.
  - **WAIT_ACK.** If `i2c_busy` is high, go to WAIT_DONE and clear the timer. If the timer reaches `TIMEOUT_CYCLES`, take the error exit.
  - **WAIT_DONE.** If `i2c_busy` is low, take the done exit. If the timer reaches `TIMEOUT_CYCLES`, take the error exit.
  - **Exits.** Clear the granted slot, pulse `done` or `error`, set `grant` to 00, flip the priority pointer, and return to IDLE.
- Priority pointer:
  - Reset value favours A.
  - When both ports are pending in IDLE, the pointer decides.
  - The pointer flips after every completed grant (done or error), so under contention the ports alternate A, B, A, B.
- A strobe on the granted port during its own transaction is ignored, because that port is still pending.
- Timer is 12 bits wide (ceil(log2(TIMEOUT_CYCLES+1))). It saturates and never wraps.

## Timing
- Reset values: every output 0, `grant` = 00, FSM in IDLE, pointer = A, slots empty, timer 0.
- Strobe latency for an idle port with the FSM idle:
  - Strobe sampled in cycle t.
  - `x_busy` = 1 in cycle t+1.
  - `grant` set and `i2c_*` valid in cycle t+2.
  - `i2c_start` = 1 in cycle t+2 only.
- Completion:
  - `i2c_busy` sampled low in WAIT_DONE in cycle d.
  - `x_done` = 1 and `x_busy` = 0 in cycle d+1.
  - A pending other port gets `i2c_start` in cycle d+3.
- Simultaneous strobes on A and B in the same cycle: both are captured, and the pointer picks the winner.
- Simultaneous strobe and done on the same port in one cycle: the strobe is ignored (slot still pending during that cycle).
- Reset asserted mid-transaction: on the next edge everything returns to reset values. No done or error pulses are generated.

## Structure
- Shared package `audio_capture_pkg` holds:
  - `I2C_ADDR_W` = 7, `I2C_DATA_W` = 8;
  - the packed command typedef (address, data_0, data_1);
  - the arbiter state enum.
- Sub-module `i2c_req_slot`, instantiated twice:
  - inputs: strobe, command, and a clear from the FSM;
  - outputs: pending and the captured command.

## Test plan
- **Single A command.** A strobe with address 0x39, data 0x41/0x10; model `i2c_busy` high for 20 cycles starting 2 cycles after `i2c_start` -> `i2c_start` at t+2 carrying 0x39/0x41/0x10; `a_done` pulses once; `a_busy` is high from t+1 to done; B is untouched.
- **Simultaneous strobes after reset.** A (0x39, 0x98/0x03) and B (0x1A, 0x1E/0x00) in the same cycle -> A is issued first; B's `i2c_start` comes exactly 2 cycles after `a_done`; a second simultaneous pair is then served B first (pointer flipped).
- **Ignored re-strobe.** Strobe A again while `a_busy` with data 0xFF/0xFF -> the issued command keeps the original bytes, and only one `a_done` occurs.
- **Ack timeout.** `i2c_busy` never rises -> `b_error` pulses exactly `TIMEOUT_CYCLES` cycles after WAIT_ACK is entered, `b_busy` falls, `grant` = 00, no `b_done`.
- **Stuck busy.** `i2c_busy` is held high -> error exit from WAIT_DONE after `TIMEOUT_CYCLES` cycles; the next A strobe is then issued normally.
- **Reset mid-operation.** Assert `rst` low in WAIT_DONE -> the next cycle shows all outputs 0 and `grant` = 00, no pulses; the first post-reset simultaneous pair is served A first.

Source files
------------

// File: rtl/audio_capture_pkg.sv
// Shared types for the I2C configuration path: command word, grant encodings and
// the arbiter state enum.
package audio_capture_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  typedef struct packed {
    logic [I2C_ADDR_W-1:0] address;
    logic [I2C_DATA_W-1:0] data_0;
    logic [I2C_DATA_W-1:0] data_1;
  } i2c_cmd_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_A    = 2'b01;
  localparam logic [1:0] GRANT_B    = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StWaitDone
  } arb_state_e;

endpackage

// File: rtl/i2c_req_slot.sv
// One requester slot: captures a command on a strobe while empty and holds it pending
// until the arbiter clears it.
module i2c_req_slot
  import audio_capture_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_strobe,
  input  i2c_cmd_t i_cmd,
  input  logic     i_clear,
  output logic     o_pending,
  output i2c_cmd_t o_cmd
);

  logic     r_pending;
  i2c_cmd_t r_cmd;

  // Clear wins, so a strobe landing on the completion cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pending <= 1'b0;
      r_cmd     <= '0;
    end else if (i_clear) begin
      r_pending <= 1'b0;
    end else if (i_strobe && !r_pending) begin
      r_pending <= 1'b1;
      r_cmd     <= i_cmd;
    end
  end

  assign o_pending = r_pending;
  assign o_cmd     = r_cmd;

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin sharing of one I2C controller between the HDMI (A) and audio codec (B)
// config queues, with a busy-handshake timeout on the controller.
module i2c_arbiter
  import audio_capture_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_start,
  input  logic [I2C_ADDR_W-1:0] a_address,
  input  logic [I2C_DATA_W-1:0] a_data_0,
  input  logic [I2C_DATA_W-1:0] a_data_1,
  input  logic                  b_start,
  input  logic [I2C_ADDR_W-1:0] b_address,
  input  logic [I2C_DATA_W-1:0] b_data_0,
  input  logic [I2C_DATA_W-1:0] b_data_1,
  output logic                  a_busy,
  output logic                  b_busy,
  output logic                  a_done,
  output logic                  b_done,
  output logic                  a_error,
  output logic                  b_error,
  output logic                  i2c_start,
  output logic [I2C_ADDR_W-1:0] i2c_address,
  output logic [I2C_DATA_W-1:0] i2c_data_0,
  output logic [I2C_DATA_W-1:0] i2c_data_1,
  input  logic                  i2c_busy,
  output logic [1:0]            grant
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerMax  = TimerW'(TIMEOUT_CYCLES);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  arb_state_e        r_state, w_state_next;
  logic [TimerW-1:0] r_timer;
  logic [1:0]        r_grant;
  logic              r_prio;
  i2c_cmd_t          r_cmd;
  logic              r_a_done, r_b_done, r_a_error, r_b_error;

  i2c_cmd_t w_cmd_in_a, w_cmd_in_b, w_cmd_a, w_cmd_b;
  logic     w_pend_a, w_pend_b, w_clr_a, w_clr_b;
  logic     w_sel_b, w_load, w_exit_done, w_exit_err, w_exit;
  logic     w_timeout, w_timer_clr, w_cooldown;

  assign w_cmd_in_a = {a_address, a_data_0, a_data_1};
  assign w_cmd_in_b = {b_address, b_data_0, b_data_1};

  i2c_req_slot u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .i_strobe  (a_start),
    .i_cmd     (w_cmd_in_a),
    .i_clear   (w_clr_a),
    .o_pending (w_pend_a),
    .o_cmd     (w_cmd_a)
  );

  i2c_req_slot u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .i_strobe  (b_start),
    .i_cmd     (w_cmd_in_b),
    .i_clear   (w_clr_b),
    .o_pending (w_pend_b),
    .o_cmd     (w_cmd_b)
  );

  assign w_sel_b     = w_pend_b && (!w_pend_a || r_prio);
  assign w_timeout   = (r_timer >= TimerLast);
  assign w_exit      = w_exit_done || w_exit_err;
  assign w_clr_a     = w_exit && r_grant[0];
  assign w_clr_b     = w_exit && r_grant[1];
  assign w_timer_clr = (r_state == StIssue) || ((r_state == StWaitAck) && i2c_busy);
  // The cycle carrying a done/error pulse is not used to grant; the next owner issues
  // two cycles after the pulse.
  assign w_cooldown  = r_a_done || r_b_done || r_a_error || r_b_error;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_exit_done  = 1'b0;
    w_exit_err   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if ((w_pend_a || w_pend_b) && !w_cooldown) begin
          w_load       = 1'b1;
          w_state_next = StIssue;
        end
      end
      StIssue: w_state_next = StWaitAck;
      StWaitAck: begin
        if (i2c_busy) begin
          w_state_next = StWaitDone;
        end else if (w_timeout) begin
          w_exit_err   = 1'b1;
          w_state_next = StIdle;
        end
      end
      StWaitDone: begin
        if (!i2c_busy) begin
          w_exit_done  = 1'b1;
          w_state_next = StIdle;
        end else if (w_timeout) begin
          w_exit_err   = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_timer   <= '0;
      r_grant   <= GRANT_NONE;
      r_prio    <= 1'b0;
      r_cmd     <= '0;
      r_a_done  <= 1'b0;
      r_b_done  <= 1'b0;
      r_a_error <= 1'b0;
      r_b_error <= 1'b0;
    end else begin
      r_a_done  <= w_exit_done && r_grant[0];
      r_b_done  <= w_exit_done && r_grant[1];
      r_a_error <= w_exit_err && r_grant[0];
      r_b_error <= w_exit_err && r_grant[1];
      if (w_timer_clr) begin
        r_timer <= '0;
      end else if (r_timer != TimerMax) begin
        r_timer <= r_timer + TimerW'(1);
      end
      if (w_load) begin
        r_cmd   <= w_sel_b ? w_cmd_b : w_cmd_a;
        r_grant <= w_sel_b ? GRANT_B : GRANT_A;
      end else if (w_exit) begin
        r_grant <= GRANT_NONE;
        r_prio  <= ~r_prio;
      end
    end
  end

  always_comb begin
    i2c_start   = (r_state == StIssue);
    i2c_address = r_cmd.address;
    i2c_data_0  = r_cmd.data_0;
    i2c_data_1  = r_cmd.data_1;
    grant       = r_grant;
    a_busy      = w_pend_a;
    b_busy      = w_pend_b;
    a_done      = r_a_done;
    b_done      = r_b_done;
    a_error     = r_a_error;
    b_error     = r_b_error;
  end

endmodule
